alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle 32-bit ALU for the MIPS datapath: the consumer end of the 6-bit ALU-control code bus driven by the ALU control decoder. It accepts a code plus operands under a start/done handshake. It produces a registered result, a zero flag and a branch-taken flag. Single-cycle ops finish in one cycle; MUL runs on an iterative shift-add engine unless the fast multiplier is compiled in.

## Interface
- No parameters (datapath fixed at 32 bits, code at 6 bits).
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state and outputs
- Start  in  1  request; sampled only when Busy=0
- ALUControl  in  6  operation code
- A  in  32  operand rs
- B  in  32  operand rt/immediate
- Shamt  in  5  shift amount for sll/srl
- RegimmRt  in  1  for code 000001: 1=BGEZ, 0=BLTZ
- ALUResult  out  32  registered result; held until the next Done
- Zero  out  1  registered (ALUResult==0), updated with ALUResult
- BranchTaken  out  1  registered branch condition, updated with ALUResult
- Busy  out  1  high while the iterative MUL is in progress
- Done  out  1  one-cycle pulse when ALUResult/Zero/BranchTaken update
- BadOp  out  1  registered; 1 if the last accepted code was unsupported

## Operation
- States: IDLE, MUL. Reset enters IDLE.
- Codes and results:
  - 100000 ADD: A+B, wrapping, no overflow trap.
  - 100010 SUB: A−B.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: bitwise.
  - 000000 sll: B<<Shamt.
  - 000010 srl: B>>Shamt, logical.
  - 101010 slt: signed A<B → 1, else 0.
  - 001000 jr: result = A.
  - 011000 MUL: low 32 bits of A×B (identical for signed and unsigned).
- Branch codes, result = A−B, BranchTaken set as follows:
  - 000100 BEQ: A==B.
  - 000101 BNE: A!=B.
  - 000111 BGTZ: signed A>0.
  - 000110 BLEZ: signed A<=0.
  - 000001: RegimmRt ? A>=0 : A<0.
- All other codes: BranchTaken=0 for every non-branch code.
- Unsupported code: result 0, Zero=1, BadOp=1, Done pulses normally.
- IDLE with Start=1 and a non-MUL code: outputs registered on that edge, Done=1 next cycle, state stays IDLE.
- IDLE with Start=1 and MUL (iterative build): latch A as multiplicand and B as multiplier, clear the accumulator and 5-bit counter, go to MUL.
- MUL, each edge:
  - if multiplier[0], accumulator += multiplicand;
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - After step 32 (counter wraps 31→0), write the accumulator to ALUResult, pulse Done, return to IDLE.
- Start while Busy=1 is ignored and not queued. A/B/ALUControl changes during MUL have no effect.

## Timing
- Reset values: ALUResult=0, Zero=1, BranchTaken=0, Busy=0, Done=0, BadOp=0, state IDLE, counter=0.
- Single-cycle op: Start in cycle k → Done and results valid in cycle k+1. Back-to-back Starts every cycle are accepted, so Done can stay high continuously.
- Iterative MUL: Start in cycle k → Busy=1 in cycles k+1..k+32 → Done=1 and Busy=0 in cycle k+33. A new Start is accepted in cycle k+33.
- Done is never high while Busy is high.
- Reset asserted mid-MUL: immediate return to reset values, no Done, partial product discarded.

## Configuration
- ALU_MUL_FAST_EN defined: MUL is computed with a combinational 32×32 multiply, treated as a single-cycle op (Done in k+1). The MUL state is never entered and Busy stays 0.
- ALU_MUL_FAST_EN undefined: iterative 32-cycle engine as described above.

## Test plan
- Reset mid-MUL: Start MUL in cycle 0, assert Reset in cycle 10 → all outputs return to reset values immediately, no Done; next ADD 1+1 → ALUResult=2 in the following cycle.
- Back-to-back: ADD 7+5, SUB 5−5, slt(−1,1), srl(0x80000000, Shamt=31) in consecutive cycles → Done held high; results 12 (Zero=0), 0 (Zero=1), 1, 1 in successive cycles.
- Branches: BEQ 4,4 → BranchTaken=1; BNE 4,4 → 0; BGTZ A=0 → 0; BLEZ A=0 → 1; 000001 with A=0xFFFFFFFF, RegimmRt=0 → 1; same with RegimmRt=1 → 0.
- Iterative MUL 0xFFFFFFFF×3, plus a Start ADD issued while Busy → ALUResult=0xFFFFFFFD, Done exactly 33 cycles after Start; the ADD is ignored (no extra Done).
- ALU_MUL_FAST_EN build, MUL 0x10000×0x10000 → ALUResult=0, Zero=1, Done next cycle, Busy never asserted.
- Unsupported code 111111 with A=B=5 → ALUResult=0, Zero=1, BadOp=1, BranchTaken=0, Done pulse; next valid op clears BadOp.

Source files
------------

// File: rtl/alu_mc_if.sv
// Request/response bundle between the ALU control decoder side and alu_mc.
// master: drives Start/ALUControl/operands, receives results; slave: the ALU.
interface alu_mc_if;
    logic        Start;
    logic [5:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic        RegimmRt;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        BranchTaken;
    logic        Busy;
    logic        Done;
    logic        BadOp;

    modport master (
        output Start, ALUControl, A, B, Shamt, RegimmRt,
        input  ALUResult, Zero, BranchTaken, Busy, Done, BadOp
    );

    modport slave (
        input  Start, ALUControl, A, B, Shamt, RegimmRt,
        output ALUResult, Zero, BranchTaken, Busy, Done, BadOp
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle 32-bit MIPS ALU with start/done handshake and registered flags.
// Ports: Clk, Reset (async, active-high), bus (alu_mc_if.slave).
// Define ALU_MUL_FAST_EN for a single-cycle combinational MUL; otherwise MUL
// runs on a 32-step shift-add engine and holds Busy while iterating.
module alu_mc (
    input  logic     Clk,
    input  logic     Reset,
    alu_mc_if.slave  bus
);

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_RIMM  = 6'b000001;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_JR    = 6'b001000;
    localparam logic [5:0] OP_MUL   = 6'b011000;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]  state;
    logic [31:0] res;
    logic        br;
    logic        bad;
    logic [31:0] diff;
    logic        a_neg;
    logic        a_zero;

    assign diff   = bus.A - bus.B;
    assign a_neg  = bus.A[31];
    assign a_zero = (bus.A == 32'd0);

    // Single-cycle datapath; result, branch decision and bad-op flag.
    always_comb begin
        res = 32'd0;
        br  = 1'b0;
        bad = 1'b0;
        unique case (bus.ALUControl)
            OP_ADD:  res = bus.A + bus.B;
            OP_SUB:  res = diff;
            OP_AND:  res = bus.A & bus.B;
            OP_OR:   res = bus.A | bus.B;
            OP_XOR:  res = bus.A ^ bus.B;
            OP_NOR:  res = ~(bus.A | bus.B);
            OP_SLL:  res = bus.B << bus.Shamt;
            OP_SRL:  res = bus.B >> bus.Shamt;
            OP_SLT:  res = {31'd0, $signed(bus.A) < $signed(bus.B)};
            OP_JR:   res = bus.A;
`ifdef ALU_MUL_FAST_EN
            OP_MUL:  res = bus.A * bus.B;
`else
            // Handled by the iterative engine; never registered from here.
            OP_MUL:  res = 32'd0;
`endif
            OP_BEQ: begin
                res = diff;
                br  = (bus.A == bus.B);
            end
            OP_BNE: begin
                res = diff;
                br  = (bus.A != bus.B);
            end
            OP_BGTZ: begin
                res = diff;
                br  = !a_neg && !a_zero;
            end
            OP_BLEZ: begin
                res = diff;
                br  = a_neg || a_zero;
            end
            OP_RIMM: begin
                res = diff;
                br  = bus.RegimmRt ? !a_neg : a_neg;
            end
            default: begin
                res = 32'd0;
                bad = 1'b1;
            end
        endcase
    end

`ifndef ALU_MUL_FAST_EN
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic [4:0]  cnt;
    logic        is_mul;

    assign is_mul  = (bus.ALUControl == OP_MUL);
    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= S_IDLE;
            bus.ALUResult   <= 32'd0;
            bus.Zero        <= 1'b1;
            bus.BranchTaken <= 1'b0;
            bus.Busy        <= 1'b0;
            bus.Done        <= 1'b0;
            bus.BadOp       <= 1'b0;
`ifndef ALU_MUL_FAST_EN
            mcand           <= 32'd0;
            mplier          <= 32'd0;
            acc             <= 32'd0;
            cnt             <= 5'd0;
`endif
        end else begin
            bus.Done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.Start) begin
`ifndef ALU_MUL_FAST_EN
                        if (is_mul) begin
                            mcand    <= bus.A;
                            mplier   <= bus.B;
                            acc      <= 32'd0;
                            cnt      <= 5'd0;
                            bus.Busy <= 1'b1;
                            state    <= S_MUL;
                        end else begin
`endif
                            bus.ALUResult   <= res;
                            bus.Zero        <= (res == 32'd0);
                            bus.BranchTaken <= br;
                            bus.BadOp       <= bad;
                            bus.Done        <= 1'b1;
`ifndef ALU_MUL_FAST_EN
                        end
`endif
                    end
                end
                S_MUL: begin
`ifndef ALU_MUL_FAST_EN
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    // Step 32 completes as the counter wraps back to 0.
                    if (cnt == 5'd31) begin
                        bus.ALUResult   <= acc_nxt;
                        bus.Zero        <= (acc_nxt == 32'd0);
                        bus.BranchTaken <= 1'b0;
                        bus.BadOp       <= 1'b0;
                        bus.Done        <= 1'b1;
                        bus.Busy        <= 1'b0;
                        state           <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed vectors, queue of expected responses,
// monitor checks each Done pulse against the head of the queue.
module tb_alu_mc;

    logic Clk;
    logic Reset;
    alu_mc_if bus ();

    alu_mc dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // {BadOp, BranchTaken, Zero, ALUResult}
    logic [34:0] expq[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] r, input logic b, input logic bo);
        expq.push_back({bo, b, (r == 32'd0), r});
    endtask

    // Drive one request for one clock edge; Start drops #1 after the edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic rt);
        bus.Start      = 1'b1;
        bus.ALUControl = op;
        bus.A          = a;
        bus.B          = b;
        bus.Shamt      = sh;
        bus.RegimmRt   = rt;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Monitor: every Done must match the oldest expected response.
    always @(negedge Clk) begin
        if (!Reset && bus.Done) begin
            chk("done_while_busy", {31'd0, bus.Busy}, 32'd0);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=%h exp=none", bus.ALUResult);
            end else begin
                logic [34:0] e;
                e = expq.pop_front();
                chk("result", bus.ALUResult, e[31:0]);
                chk("zero", {31'd0, bus.Zero}, {31'd0, e[32]});
                chk("branch", {31'd0, bus.BranchTaken}, {31'd0, e[33]});
                chk("badop", {31'd0, bus.BadOp}, {31'd0, e[34]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int busy_n;
        bus.Start      = 1'b0;
        bus.ALUControl = 6'd0;
        bus.A          = 32'd0;
        bus.B          = 32'd0;
        bus.Shamt      = 5'd0;
        bus.RegimmRt   = 1'b0;
        Reset          = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_result", bus.ALUResult, 32'd0);
        chk("rst_zero", {31'd0, bus.Zero}, 32'd1);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_badop", {31'd0, bus.BadOp}, 32'd0);
        chk("rst_br", {31'd0, bus.BranchTaken}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Back-to-back single-cycle ops keep Done high.
        push(32'd12, 1'b0, 1'b0);
        issue(6'b100000, 32'd7, 32'd5, 5'd0, 1'b0);
        push(32'd0, 1'b0, 1'b0);
        issue(6'b100010, 32'd5, 32'd5, 5'd0, 1'b0);
        push(32'd1, 1'b0, 1'b0);
        issue(6'b101010, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
        push(32'd1, 1'b0, 1'b0);
        issue(6'b000010, 32'd0, 32'h80000000, 5'd31, 1'b0);
        chk("b2b_done_held", {31'd0, bus.Done}, 32'd1);

        // Other single-cycle ops.
        push(32'h0000F000, 1'b0, 1'b0);
        issue(6'b100100, 32'h0000F0F0, 32'h0000FF00, 5'd0, 1'b0);
        push(32'h000000F0, 1'b0, 1'b0);
        issue(6'b100110, 32'h000000FF, 32'h0000000F, 5'd0, 1'b0);
        push(32'hFFFFFFFF, 1'b0, 1'b0);
        issue(6'b100111, 32'd0, 32'd0, 5'd0, 1'b0);
        push(32'd16, 1'b0, 1'b0);
        issue(6'b000000, 32'd0, 32'd1, 5'd4, 1'b0);
        push(32'h00001234, 1'b0, 1'b0);
        issue(6'b001000, 32'h00001234, 32'd9, 5'd0, 1'b0);

        // Branches.
        push(32'd0, 1'b1, 1'b0);
        issue(6'b000100, 32'd4, 32'd4, 5'd0, 1'b0);
        push(32'd0, 1'b0, 1'b0);
        issue(6'b000101, 32'd4, 32'd4, 5'd0, 1'b0);
        push(32'd0, 1'b0, 1'b0);
        issue(6'b000111, 32'd0, 32'd0, 5'd0, 1'b0);
        push(32'd0, 1'b1, 1'b0);
        issue(6'b000110, 32'd0, 32'd0, 5'd0, 1'b0);
        push(32'hFFFFFFFF, 1'b1, 1'b0);
        issue(6'b000001, 32'hFFFFFFFF, 32'd0, 5'd0, 1'b0);
        push(32'hFFFFFFFF, 1'b0, 1'b0);
        issue(6'b000001, 32'hFFFFFFFF, 32'd0, 5'd0, 1'b1);

        // Unsupported code, then a valid op clears BadOp.
        push(32'd0, 1'b0, 1'b1);
        issue(6'b111111, 32'd5, 32'd5, 5'd0, 1'b0);
        push(32'd7, 1'b0, 1'b0);
        issue(6'b100101, 32'd5, 32'd3, 5'd0, 1'b0);
        repeat (3) @(negedge Clk);

`ifdef ALU_MUL_FAST_EN
        push(32'd0, 1'b0, 1'b0);
        issue(6'b011000, 32'h00010000, 32'h00010000, 5'd0, 1'b0);
        busy_n = 0;
        n = 0;
        while (n < 36) begin
            @(negedge Clk);
            n++;
            if (bus.Busy) busy_n++;
        end
        chk("fast_busy_cycles", busy_n, 32'd0);
        push(32'h00000006, 1'b0, 1'b0);
        issue(6'b011000, 32'd3, 32'd2, 5'd0, 1'b0);
        @(negedge Clk);
        chk("fast_done_k1", {31'd0, bus.Done}, 32'd1);
`else
        // Iterative MUL, with an ADD start issued mid-run that must be dropped.
        push(32'hFFFFFFFD, 1'b0, 1'b0);
        issue(6'b011000, 32'hFFFFFFFF, 32'd3, 5'd0, 1'b0);
        n = 0;
        busy_n = 0;
        while (n < 40) begin
            @(negedge Clk);
            n++;
            if (n == 5) begin
                bus.Start      = 1'b1;
                bus.ALUControl = 6'b100000;
                bus.A          = 32'd1;
                bus.B          = 32'd2;
            end
            if (n == 6) bus.Start = 1'b0;
            if (bus.Busy) busy_n++;
            if (bus.Done) break;
        end
        chk("mul_latency", n, 32'd33);
        chk("mul_busy_cycles", busy_n, 32'd32);
        repeat (4) @(negedge Clk);
        chk("mul_hold_result", bus.ALUResult, 32'hFFFFFFFD);

        // Reset mid-MUL: start in cycle 0, reset in cycle 10.
        issue(6'b011000, 32'd9, 32'd9, 5'd0, 1'b0);
        repeat (9) @(negedge Clk);
        chk("pre_rst_busy", {31'd0, bus.Busy}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("mrst_result", bus.ALUResult, 32'd0);
        chk("mrst_zero", {31'd0, bus.Zero}, 32'd1);
        chk("mrst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("mrst_done", {31'd0, bus.Done}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        push(32'd2, 1'b0, 1'b0);
        issue(6'b100000, 32'd1, 32'd1, 5'd0, 1'b0);
        @(negedge Clk);
        chk("post_rst_add", bus.ALUResult, 32'd2);
`endif

        repeat (40) @(negedge Clk);
        chk("queue_drained", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
